eeprom_req_sched: RTL
=====================

Name: eeprom_req_sched

Overview:
- Round-robin scheduler that shares one eeprom_cntl instance between two requester ports, A and B.
- Each requester asks for one 32-byte page operation: write (EEPROM_WR) or read (EEPROM_RD).
- The block fills or drains the controller's 32-entry buffer, drives the cmd/data address protocol, waits out busy, and returns per-requester done/error.
- It sits between application logic and eeprom_cntl.

Parameters:
- PAGE_BYTES, 32: bytes moved per operation; must equal the controller buffer depth.
- START_TMO, 16'd64: max cycles from address issue to busy rising before the op is declared failed.
- WDOG_CYC, 32'd2_000_000: busy watchdog limit in cycles (used only with EEPROM_SCHED_WDOG_EN).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- req_a / req_b  in  1  request, held until done_x
- op_a / op_b  in  1  0 = write page, 1 = read page; sampled at grant
- addr_a / addr_b  in  16  EEPROM word address; sampled at grant
- wdata_a / wdata_b  in  8  write byte
- wvalid_a / wvalid_b  in  1  write byte valid
- wready_a / wready_b  out  1  write byte accepted when wvalid & wready
- rdata  out  8  read byte (shared)
- rvalid_a / rvalid_b  out  1  rdata valid for that requester; no backpressure
- done_a / done_b  out  1  one-cycle completion pulse
- err_a / err_b  out  1  status qualifying done_x; held until the next grant to that port
- ctl_cmd  out  2  to eeprom_cntl cmd (NOP=00, WR=01, RD=10, LDA=11)
- ctl_data  inout  8  to eeprom_cntl data
- ctl_buf_reset / ctl_buf_rd_en / ctl_buf_wr_en  out  1  buffer controls
- ctl_buf_empty / ctl_buf_full / ctl_error / ctl_busy  in  1  controller status

Behaviour:
- Reset: all outputs 0, ctl_cmd = NOP, ctl_data = Z, FSM in IDLE, round-robin pointer favours A.
- ctl_data drive rule: driven only when ctl_cmd != NOP or ctl_buf_wr_en = 1; otherwise Z.
- FSM states: IDLE, GRANT, CLR, FILL, ADDR_LO, ADDR_HI, WAIT_START, WAIT_DONE, DRAIN, FIN.
- IDLE -> GRANT when any req is set.
- Arbitration in GRANT:
  - Only one requester asserting: it wins.
  - Both asserting: the port not granted last wins.
  - op, addr and owner are latched.
- CLR: ctl_buf_reset for 1 cycle.
  - Write -> FILL.
  - Read -> ADDR_LO.
- FILL (write only):
  - wready_owner = 1 unless ctl_buf_full.
  - Each accepted byte drives ctl_data = wdata with ctl_buf_wr_en = 1 in the same cycle.
  - Byte counter 0..31; leave to ADDR_LO after PAGE_BYTES accepted.
  - ctl_buf_full asserting early is an overflow: set err, go to FIN.
- ADDR_LO: ctl_cmd = op ? RD : WR, ctl_data = addr[7:0]; 1 cycle.
- ADDR_HI: same cmd, ctl_data = addr[15:8]; 1 cycle. Then ctl_cmd returns to NOP.
- WAIT_START:
  - -> WAIT_DONE on ctl_busy = 1.
  - Counter reaching START_TMO: err = 1, -> FIN.
- WAIT_DONE: on ctl_busy falling, sample ctl_error.
  - ctl_error = 1: err, -> FIN.
  - Else read -> DRAIN; write -> FIN.
- DRAIN (read only), data first-word-fall-through:
  - While !ctl_buf_empty: rdata = ctl_data, rvalid_owner = 1, ctl_buf_rd_en = 1 in the same cycle.
  - -> FIN after PAGE_BYTES bytes.
  - Empty before 32 bytes: err, -> FIN.
- FIN: done_owner pulses 1 cycle; pointer updates; -> IDLE.
- A req dropped mid-operation is ignored; the operation completes.
- Latency, write: grant 1 + clear 1 + 32 fill (minimum) + 2 address cycles + controller time + 1.
- Latency, read: grant 1 + clear 1 + 2 address cycles + controller time + 32 drain + 1.
- Reset mid-op: immediate return to IDLE, no done pulse.

Optional Feature:
- Macro: EEPROM_SCHED_WDOG_EN.
- Defined: a 32-bit counter runs in WAIT_DONE. Reaching WDOG_CYC sets err, ctl_buf_reset pulses, FSM -> FIN.
- Undefined: WAIT_DONE waits on busy indefinitely; WDOG_CYC is unused.

Decomposition:
- Shared package eeprom_pkg holds:
  - cmd encodings NOP/WR/RD/LDA
  - PAGE_BYTES
  - FSM state localparams
  - CLK_FREQ
- One sub-module: rr_arb2, a 2-way round-robin arbiter (req[1:0], advance -> grant one-hot, last-owner pointer).

Test Plan:
- Write, A only: op_a=0, addr_a=16'h0120, 32 bytes 0x00..0x1F, model asserts busy 100 cycles -> ADDR_LO shows cmd=01 data=20h, ADDR_HI data=01h; done_a with err_a=0.
- Read, B only: op_b=1, addr_b=16'h0040, model holds bytes 0xA0..0xBF -> rvalid_b 32 times in order A0..BF; done_b with err_b=0.
- Contention: req_a and req_b raised in the same cycle twice in a row -> grants A, B, A, B; no overlap of ctl_cmd activity.
- NACK: model returns ctl_error=1 at busy fall -> done with err=1, no rvalid pulses.
- Start timeout: busy never rises -> done with err=1 after START_TMO cycles.
- Watchdog (EEPROM_SCHED_WDOG_EN, WDOG_CYC=1000): busy held high -> err=1, ctl_buf_reset pulse, done at 1000+1 cycles after busy rose.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared definitions for the eeprom_cntl request scheduler: controller command
// codes, page size, clock frequency and the scheduler FSM state encoding.
package eeprom_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_LDA = 2'b11;

  localparam int PAGE_BYTES = 32;
  localparam int CLK_FREQ   = 50_000_000;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_GRANT      = 4'd1,
    ST_CLR        = 4'd2,
    ST_FILL       = 4'd3,
    ST_ADDR_LO    = 4'd4,
    ST_ADDR_HI    = 4'd5,
    ST_WAIT_START = 4'd6,
    ST_WAIT_DONE  = 4'd7,
    ST_DRAIN      = 4'd8,
    ST_FIN        = 4'd9
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The winner is captured on lock_i and becomes
// the "last owner" only on advance_i, so an aborted operation never moves the pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       owner_o
);

  // last_q = 1 means B was served last, so A wins the next tie.
  logic last_q;
  logic owner_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      if (lock_i)    owner_q <= grant_o[1];
      if (advance_i) last_q  <= owner_q;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/eeprom_req_sched.sv
// Round-robin scheduler sharing one eeprom_cntl between requesters A and B.
// Optional busy watchdog in WAIT_DONE is enabled with `define EEPROM_SCHED_WDOG_EN.
module eeprom_req_sched
  import eeprom_pkg::*;
#(
  parameter logic [15:0] START_TMO = 16'd64,
  parameter logic [31:0] WDOG_CYC  = 32'd2_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        op_a,
  input  logic        op_b,
  input  logic [15:0] addr_a,
  input  logic [15:0] addr_b,
  input  logic [7:0]  wdata_a,
  input  logic [7:0]  wdata_b,
  input  logic        wvalid_a,
  input  logic        wvalid_b,
  output logic        wready_a,
  output logic        wready_b,
  output logic [7:0]  rdata,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic        done_a,
  output logic        done_b,
  output logic        err_a,
  output logic        err_b,
  output logic [1:0]  ctl_cmd,
  inout  wire  [7:0]  ctl_data,
  output logic        ctl_buf_reset,
  output logic        ctl_buf_rd_en,
  output logic        ctl_buf_wr_en,
  input  logic        ctl_buf_empty,
  input  logic        ctl_buf_full,
  input  logic        ctl_error,
  input  logic        ctl_busy,
  output logic [3:0]  dbg_state
);

  // Handshake: a write byte moves on a cycle with wvalid_x & wready_x high;
  // rvalid_x and done_x are single-cycle strobes with no backpressure.
  localparam logic [15:0] LAST_BYTE = 16'(PAGE_BYTES - 1);
  localparam logic [15:0] TMO_LAST  = START_TMO - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  dout;
  logic        drive;
  logic [1:0]  grant;
  logic        owner;
  logic        arb_lock, arb_adv;
  logic        wvalid_own;
  logic [7:0]  wdata_own;

`ifdef EEPROM_SCHED_WDOG_EN
  localparam logic [31:0] WDOG_LAST = WDOG_CYC - 32'd1;
  logic [31:0] wdog_q, wdog_d;
`else
  logic [31:0] unused_wdog;
  assign unused_wdog = WDOG_CYC;
`endif

  rr_arb2 u_arb (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .req_i     ({req_b, req_a}),
    .lock_i    (arb_lock),
    .advance_i (arb_adv),
    .grant_o   (grant),
    .owner_o   (owner)
  );

  assign wvalid_own = owner ? wvalid_b : wvalid_a;
  assign wdata_own  = owner ? wdata_b  : wdata_a;
  assign err_a      = err_q[0];
  assign err_b      = err_q[1];
  assign dbg_state  = state_q;

  // The bus is released whenever neither a command nor a buffer write is in
  // flight, so the controller can present FWFT read data.
  assign drive    = (ctl_cmd != CMD_NOP) || ctl_buf_wr_en;
  assign ctl_data = drive ? dout : 8'hzz;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      err_q   <= '0;
`ifdef EEPROM_SCHED_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef EEPROM_SCHED_WDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    addr_d        = addr_q;
    err_d         = err_q;
    dout          = 8'h00;
    ctl_cmd       = CMD_NOP;
    ctl_buf_reset = 1'b0;
    ctl_buf_rd_en = 1'b0;
    ctl_buf_wr_en = 1'b0;
    wready_a      = 1'b0;
    wready_b      = 1'b0;
    rvalid_a      = 1'b0;
    rvalid_b      = 1'b0;
    rdata         = 8'h00;
    done_a        = 1'b0;
    done_b        = 1'b0;
    arb_lock      = 1'b0;
    arb_adv       = 1'b0;
`ifdef EEPROM_SCHED_WDOG_EN
    wdog_d        = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        // A requester that dropped before the grant simply sends us back.
        if (grant != 2'b00) begin
          arb_lock         = 1'b1;
          op_d             = grant[1] ? op_b : op_a;
          addr_d           = grant[1] ? addr_b : addr_a;
          err_d[grant[1]]  = 1'b0;
          cnt_d            = '0;
          state_d          = ST_CLR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        ctl_buf_reset = 1'b1;
        cnt_d         = '0;
        state_d       = op_q ? ST_ADDR_LO : ST_FILL;
      end
      ST_FILL: begin
        if (ctl_buf_full) begin
          err_d[owner] = 1'b1;
          state_d      = ST_FIN;
        end else begin
          if (owner) wready_b = 1'b1;
          else       wready_a = 1'b1;
          if (wvalid_own) begin
            ctl_buf_wr_en = 1'b1;
            dout          = wdata_own;
            cnt_d         = cnt_q + 16'd1;
            if (cnt_q == LAST_BYTE) state_d = ST_ADDR_LO;
          end
        end
      end
      ST_ADDR_LO: begin
        ctl_cmd = op_q ? CMD_RD : CMD_WR;
        dout    = addr_q[7:0];
        state_d = ST_ADDR_HI;
      end
      ST_ADDR_HI: begin
        ctl_cmd = op_q ? CMD_RD : CMD_WR;
        dout    = addr_q[15:8];
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (ctl_busy) begin
          state_d = ST_WAIT_DONE;
`ifdef EEPROM_SCHED_WDOG_EN
          wdog_d  = '0;
`endif
        end else if (cnt_q == TMO_LAST) begin
          err_d[owner] = 1'b1;
          state_d      = ST_FIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!ctl_busy) begin
          cnt_d = '0;
          if (ctl_error) begin
            err_d[owner] = 1'b1;
            state_d      = ST_FIN;
          end else begin
            state_d = op_q ? ST_DRAIN : ST_FIN;
          end
        end
`ifdef EEPROM_SCHED_WDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          err_d[owner]  = 1'b1;
          ctl_buf_reset = 1'b1;
          state_d       = ST_FIN;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
`endif
      end
      ST_DRAIN: begin
        if (ctl_buf_empty) begin
          err_d[owner] = 1'b1;
          state_d      = ST_FIN;
        end else begin
          ctl_buf_rd_en = 1'b1;
          rdata         = ctl_data;
          if (owner) rvalid_b = 1'b1;
          else       rvalid_a = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_BYTE) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (owner) done_b = 1'b1;
        else       done_a = 1'b1;
        arb_adv = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
